abc_code_sequencer: RTL

Timed 3-bit code generator that produces the {A, B, C} select code consumed by the 3-to-5 grouped active-low decoder stage. A programmable prescaler sets the clock cycles per step, and the code counts up, down, or ping-pong. The block also flags every step and every terminal/bounce event for downstream logic and for the bench. Outputs are registered so the decoder sees glitch-free codes.

---
 rtl/abc_code_sequencer.sv | 134 +++++++++++++
 1 files changed

// File: rtl/abc_code_sequencer.sv
// abc_code_sequencer
// Timed 3-bit {a, b, c} select-code generator for the grouped active-low
// decoder stage. A prescaler sets the cycles per step; the code counts up,
// down or ping-pong, and one-cycle step / terminal-count flags accompany
// each new code. Every output comes straight from a register, so the
// decoder never sees a glitch and there is no input-to-output path.

module abc_code_sequencer #(
  parameter int PRESCALE = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [1:0] mode,
  input  logic       load,
  input  logic [2:0] d,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic       step,
  output logic       tc
);

  // Prescaler width: at least one bit, even when PRESCALE is 1.
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PCNT_LAST = PW'(PRESCALE - 1);

  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_UP   = 2'b01;
  localparam logic [1:0] MODE_DOWN = 2'b10;
  localparam logic [1:0] MODE_PING = 2'b11;

  // Ping-pong direction. It only changes on a bounce or a load.
  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_t;

  logic [2:0]    code_reg, code_next;
  logic [PW-1:0] pcnt_reg, pcnt_next;
  dir_t          pdir_reg, pdir_next;
  logic          step_reg, step_next;
  logic          tc_reg,   tc_next;

  logic          run;
  logic          at_last;

  // A run cycle needs enable, a non-hold mode and no load. Load outranks run.
  assign run     = en && (mode != MODE_HOLD) && !load;
  assign at_last = (pcnt_reg == PCNT_LAST);

  // State register. Reset is asynchronous and clears everything at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      code_reg <= 3'b000;
      pcnt_reg <= '0;
      pdir_reg <= DIR_UP;
      step_reg <= 1'b0;
      tc_reg   <= 1'b0;
    end else begin
      code_reg <= code_next;
      pcnt_reg <= pcnt_next;
      pdir_reg <= pdir_next;
      step_reg <= step_next;
      tc_reg   <= tc_next;
    end
  end

  // Next-state logic: load, then prescaled advance, otherwise hold.
  always_comb begin
    code_next = code_reg;
    pcnt_next = pcnt_reg;
    pdir_next = pdir_reg;
    step_next = 1'b0;
    tc_next   = 1'b0;

    if (load) begin
      // A load restarts the step interval and the ping-pong direction.
      code_next = d;
      pcnt_next = '0;
      pdir_next = DIR_UP;
    end else if (run) begin
      if (!at_last) begin
        pcnt_next = pcnt_reg + 1'b1;
      end else begin
        pcnt_next = '0;
        step_next = 1'b1;
        case (mode)
          MODE_UP: begin
            code_next = code_reg + 3'd1;
            tc_next   = (code_reg == 3'd7);
          end
          MODE_DOWN: begin
            code_next = code_reg - 3'd1;
            tc_next   = (code_reg == 3'd0);
          end
          MODE_PING: begin
            if (pdir_reg == DIR_UP) begin
              if (code_reg == 3'd7) begin
                // Bounce off the top. 7 is not repeated.
                code_next = 3'd6;
                pdir_next = DIR_DOWN;
                tc_next   = 1'b1;
              end else begin
                code_next = code_reg + 3'd1;
              end
            end else begin
              if (code_reg == 3'd0) begin
                // Bounce off the bottom. 0 is not repeated.
                code_next = 3'd1;
                pdir_next = DIR_UP;
                tc_next   = 1'b1;
              end else begin
                code_next = code_reg - 3'd1;
              end
            end
          end
          default: begin
            // A hold mode never counts as a run cycle. Keep the code.
            code_next = code_reg;
          end
        endcase
      end
    end
  end

  // a is the MSB of the code and c is the LSB.
  assign a    = code_reg[2];
  assign b    = code_reg[1];
  assign c    = code_reg[0];
  assign step = step_reg;
  assign tc   = tc_reg;

endmodule
